// File: rtl/spi_cmd_target.sv
// SPI mode-0 command target: decodes command/address/data frames into a single-request bus.
// SPI pins are oversampled in the clk domain; nothing is clocked by spi_sclk itself.
module spi_cmd_target #(
  parameter int ADDR_WIDTH  = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_rx,
  output logic                  spi_tx,
  output logic [ADDR_WIDTH-1:0] spi_addr,
  output logic [7:0]            spi_wr_data,
  output logic                  spi_rw_b,
  output logic                  spi_req,
  input  logic                  spi_ack,
  input  logic [7:0]            spi_rd_data,
  output logic                  spi_overrun
);

  typedef enum logic [2:0] {
    S_CMD, S_ADDR_HI, S_ADDR_LO, S_WR_DATA, S_RD_DATA, S_IGNORE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, rx_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, cs_active, rx_s, sclk_rise, sclk_fall;
  logic [2:0]             rx_cnt_q, tx_cnt_q;
  logic [7:0]             rx_sr_q, tx_sr_q, tx_sr_d, rx_byte;
  logic                   byte_done, reload, late_rd;
  logic                   cmd_rd_q;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, req_addr_q;
  logic [7:0]             rd_data_q, wr_data_q;
  logic                   rd_valid_q, req_q, rw_b_q, overrun_q;
  logic                   want_req, issue, drop, ack_seen, want_rd;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_active = ~cs_sync_q[SYNC_STAGES-1];
  assign rx_s      = rx_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  assign rx_byte   = {rx_sr_q[6:0], rx_s};
  assign byte_done = cs_active & sclk_rise & (rx_cnt_q == 3'd7);
  assign reload    = cs_active & sclk_fall & (tx_cnt_q == 3'd7);
  assign late_rd   = reload & (state_q == S_RD_DATA) & ~rd_valid_q;

  assign want_rd   = byte_done & ((state_q == S_RD_DATA) | ((state_q == S_ADDR_LO) & cmd_rd_q));
  assign want_req  = want_rd | (byte_done & (state_q == S_WR_DATA));
  assign issue     = want_req & ~req_q;
  assign drop      = want_req & req_q;
  assign ack_seen  = req_q & spi_ack;

  always_comb begin
    state_d = state_q;
    if (!cs_active) begin
      state_d = S_CMD;
    end else if (byte_done) begin
      case (state_q)
        S_CMD: begin
          if (rx_byte[7:4] == 4'd1 || rx_byte[7:4] == 4'd2) state_d = S_ADDR_HI;
          else if (rx_byte[7:4] == 4'd0)                   state_d = S_CMD;
          else                                             state_d = S_IGNORE;
        end
        S_ADDR_HI: state_d = S_ADDR_LO;
        S_ADDR_LO: state_d = cmd_rd_q ? S_RD_DATA : S_WR_DATA;
        S_WR_DATA: state_d = S_WR_DATA;
        S_RD_DATA: state_d = S_RD_DATA;
        S_IGNORE:  state_d = S_IGNORE;
        default:   state_d = S_CMD;
      endcase
    end
  end

  always_comb begin
    addr_d = addr_q;
    if (byte_done && state_q == S_CMD) begin
      for (int i = 16; i < ADDR_WIDTH; i++) addr_d[i] = rx_byte[i-16];
    end else if (byte_done && state_q == S_ADDR_HI) begin
      addr_d[15:8] = rx_byte;
    end else if (byte_done && state_q == S_ADDR_LO) begin
      addr_d[7:0] = rx_byte;
    end else if (ack_seen) begin
      addr_d = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Read data only goes out in RD_DATA, and only if the ack beat the byte boundary.
  always_comb begin
    tx_sr_d = tx_sr_q;
    if (!cs_active) begin
      tx_sr_d = 8'h00;
    end else if (sclk_fall) begin
      if (tx_cnt_q == 3'd7)
        tx_sr_d = (state_q == S_RD_DATA && rd_valid_q) ? rd_data_q : 8'h00;
      else
        tx_sr_d = {tx_sr_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_CMD;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      rx_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      rx_cnt_q    <= 3'd0;
      tx_cnt_q    <= 3'd0;
      rx_sr_q     <= 8'h00;
      tx_sr_q     <= 8'h00;
      cmd_rd_q    <= 1'b0;
      addr_q      <= '0;
      req_addr_q  <= '0;
      rd_data_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      req_q       <= 1'b0;
      rw_b_q      <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      rx_sync_q   <= {rx_sync_q[SYNC_STAGES-2:0], spi_rx};
      sclk_prev_q <= sclk_s;
      addr_q      <= addr_d;
      tx_sr_q     <= tx_sr_d;
      overrun_q   <= drop | late_rd;

      if (!cs_active) begin
        rx_cnt_q <= 3'd0;
        tx_cnt_q <= 3'd0;
        rx_sr_q  <= 8'h00;
      end else begin
        if (sclk_rise) begin
          rx_cnt_q <= rx_cnt_q + 3'd1;
          rx_sr_q  <= rx_byte;
        end
        if (sclk_fall) tx_cnt_q <= tx_cnt_q + 3'd1;
      end

      if (byte_done && state_q == S_CMD) cmd_rd_q <= (rx_byte[7:4] == 4'd2);

      if (issue) begin
        req_q      <= 1'b1;
        req_addr_q <= addr_d;
        rw_b_q     <= want_rd;
        if (!want_rd) wr_data_q <= rx_byte;
      end else if (ack_seen) begin
        req_q <= 1'b0;
      end

      // A fresh read request invalidates older data so a stale byte is never returned.
      if (!cs_active || (issue && want_rd)) rd_valid_q <= 1'b0;
      else if (ack_seen && rw_b_q)          rd_valid_q <= 1'b1;
      else if (reload)                      rd_valid_q <= 1'b0;

      if (ack_seen && rw_b_q) rd_data_q <= spi_rd_data;
    end
  end

  assign spi_tx      = tx_sr_q[7];
  assign spi_addr    = req_addr_q;
  assign spi_wr_data = wr_data_q;
  assign spi_rw_b    = rw_b_q;
  assign spi_req     = req_q;
  assign spi_overrun = overrun_q;

endmodule

// File: tb/tb_spi_cmd_target.sv
// Directed bench for spi_cmd_target: table of write frames plus hand-written read/overrun/reset cases.
module tb_spi_cmd_target;
  localparam int AW   = 17;
  localparam int HALF = 80;

  logic          clk, reset, spi_sclk, spi_cs_n, spi_rx, spi_tx;
  logic [AW-1:0] spi_addr;
  logic [7:0]    spi_wr_data, spi_rd_data;
  logic          spi_rw_b, spi_req, spi_ack, spi_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int n_req    = 0;
  int ovr_cnt  = 0;
  int wait_cnt = 0;
  int ack_delay = 1;
  bit ack_hold  = 1'b0;

  logic [AW-1:0] log_addr  [32];
  logic          log_rw    [32];
  logic [7:0]    log_wd    [32];
  logic          log_after [32];

  typedef struct {
    logic [7:0]    cmd, ahi, alo, data;
    logic [AW-1:0] exp_addr;
  } wr_vec_t;

  spi_cmd_target #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_rx(spi_rx), .spi_tx(spi_tx),
    .spi_addr(spi_addr), .spi_wr_data(spi_wr_data), .spi_rw_b(spi_rw_b),
    .spi_req(spi_req), .spi_ack(spi_ack), .spi_rd_data(spi_rd_data),
    .spi_overrun(spi_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus responder: acks after ack_delay cycles, returns 0xA1 + addr[7:0] for reads, logs each transfer.
  initial begin
    spi_ack     = 1'b0;
    spi_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (spi_ack) begin
        if (n_req > 0 && n_req <= 32) log_after[n_req-1] = spi_req;
        spi_ack = 1'b0;
      end else if (spi_req === 1'b1 && !ack_hold) begin
        if (wait_cnt >= ack_delay) begin
          if (n_req < 32) begin
            log_addr[n_req] = spi_addr;
            log_rw[n_req]   = spi_rw_b;
            log_wd[n_req]   = spi_wr_data;
          end
          spi_rd_data = spi_rw_b ? 8'hA1 + spi_addr[7:0] : 8'h00;
          spi_ack     = 1'b1;
          n_req++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
      if (spi_overrun === 1'b1) ovr_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    #(4*HALF);
  endtask

  task automatic cs_high();
    #HALF;
    spi_cs_n = 1'b1;
    #(4*HALF);
  endtask

  task automatic xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_rx = mosi[i];
      #HALF;
      m[i] = spi_tx;
      spi_sclk = 1'b1;
      #HALF;
      spi_sclk = 1'b0;
    end
    miso = m;
  endtask

  task automatic frame4(input logic [7:0] b0, b1, b2, b3);
    logic [7:0] m;
    cs_low();
    xfer(b0, 8, m); xfer(b1, 8, m); xfer(b2, 8, m); xfer(b3, 8, m);
    cs_high();
  endtask

  wr_vec_t    vecs [4];
  int         base, obase;
  logic [7:0] m0, m1, m2, m3;

  initial begin
    vecs[0] = '{8'h11, 8'h23, 8'h45, 8'h67, 17'h12345};
    vecs[1] = '{8'h10, 8'h00, 8'h01, 8'h55, 17'h00001};
    vecs[2] = '{8'h11, 8'hFF, 8'h00, 8'h3C, 17'h1FF00};
    vecs[3] = '{8'h10, 8'hAB, 8'hCD, 8'h00, 17'h0ABCD};

    reset = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_rx = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req", spi_req, 0);
    check("rst_rw_b", spi_rw_b, 1);
    check("rst_addr", spi_addr, 0);
    check("rst_wr_data", spi_wr_data, 0);
    check("rst_tx", spi_tx, 0);
    check("rst_overrun", spi_overrun, 0);

    // Table of single-byte writes: one request each, req drops the cycle after ack.
    for (int v = 0; v < 4; v++) begin
      base = n_req;
      frame4(vecs[v].cmd, vecs[v].ahi, vecs[v].alo, vecs[v].data);
      check($sformatf("wr%0d_count", v), n_req - base, 1);
      check($sformatf("wr%0d_addr", v), log_addr[base], vecs[v].exp_addr);
      check($sformatf("wr%0d_rw_b", v), log_rw[base], 0);
      check($sformatf("wr%0d_data", v), log_wd[base], vecs[v].data);
      check($sformatf("wr%0d_req_after_ack", v), log_after[base], 0);
    end

    // Burst read at 0x08000 with timely acks.
    base = n_req; obase = ovr_cnt; ack_delay = 1;
    cs_low();
    xfer(8'h20, 8, m0); xfer(8'h80, 8, m0); xfer(8'h00, 8, m0);
    xfer(8'hFF, 8, m1); xfer(8'hFF, 8, m2); xfer(8'hFF, 8, m3);
    cs_high();
    check("rd_miso1", m1, 8'hA1);
    check("rd_miso2", m2, 8'hA2);
    check("rd_miso3", m3, 8'hA3);
    check("rd_addr0", log_addr[base], 17'h08000);
    check("rd_addr1", log_addr[base+1], 17'h08001);
    check("rd_addr2", log_addr[base+2], 17'h08002);
    check("rd_rw_b", log_rw[base], 1);
    check("rd_overrun", ovr_cnt - obase, 0);

    // Late read: first ack arrives after the byte boundary reload.
    base = n_req; obase = ovr_cnt; ack_delay = 20;
    cs_low();
    xfer(8'h20, 8, m0); xfer(8'h00, 8, m0); xfer(8'h10, 8, m0);
    #300;
    ack_delay = 1;
    xfer(8'hFF, 8, m1); xfer(8'hFF, 8, m2);
    cs_high();
    check("late_miso1", m1, 8'h00);
    check("late_miso2", m2, 8'hB2);
    check("late_overrun", ovr_cnt - obase, 1);
    check("late_addr0", log_addr[base], 17'h00010);

    // Write burst wrapping past the top of the address space.
    base = n_req;
    cs_low();
    xfer(8'h11, 8, m0); xfer(8'hFF, 8, m0); xfer(8'hFF, 8, m0);
    xfer(8'h5A, 8, m0); xfer(8'hA5, 8, m0);
    cs_high();
    check("wrap_count", n_req - base, 2);
    check("wrap_addr0", log_addr[base], 17'h1FFFF);
    check("wrap_addr1", log_addr[base+1], 17'h00000);
    check("wrap_data1", log_wd[base+1], 8'hA5);

    // Unknown opcode: no requests and MISO stays zero.
    base = n_req;
    cs_low();
    xfer(8'h70, 8, m0); xfer(8'hFF, 8, m0); xfer(8'hFF, 8, m1);
    xfer(8'hFF, 8, m2); xfer(8'hFF, 8, m3);
    cs_high();
    check("ign_count", n_req - base, 0);
    check("ign_miso", m0 | m1 | m2 | m3, 8'h00);
    frame4(8'h10, 8'h00, 8'h01, 8'h55);
    check("ign_next_addr", log_addr[base], 17'h00001);
    check("ign_next_data", log_wd[base], 8'h55);

    // Second data byte lands while the first request is still pending: dropped.
    base = n_req; obase = ovr_cnt; ack_hold = 1'b1;
    cs_low();
    xfer(8'h10, 8, m0); xfer(8'h01, 8, m0); xfer(8'h00, 8, m0);
    xfer(8'h11, 8, m0); xfer(8'h22, 8, m0);
    cs_high();
    check("drop_overrun", ovr_cnt - obase, 1);
    check("drop_req_held", spi_req, 1);
    check("drop_wr_data", spi_wr_data, 8'h11);
    ack_hold = 1'b0;
    repeat (20) @(negedge clk);
    check("drop_count", n_req - base, 1);
    check("drop_addr", log_addr[base], 17'h00100);

    // cs_n rises mid ADDR_LO: partial byte discarded, next frame decodes from CMD.
    base = n_req;
    cs_low();
    xfer(8'h11, 8, m0); xfer(8'h22, 8, m0); xfer(8'h33, 4, m0);
    cs_high();
    check("abort_count", n_req - base, 0);
    frame4(8'h10, 8'h00, 8'h02, 8'h77);
    check("abort_next_addr", log_addr[base], 17'h00002);
    check("abort_next_data", log_wd[base], 8'h77);

    // Reset while a request is outstanding drops it without an ack.
    base = n_req; ack_hold = 1'b1;
    frame4(8'h10, 8'h00, 8'h03, 8'h99);
    check("rstmid_req_before", spi_req, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("rstmid_req_async", spi_req, 0);
    check("rstmid_rw_b", spi_rw_b, 1);
    check("rstmid_addr", spi_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    ack_hold = 1'b0;
    repeat (20) @(negedge clk);
    check("rstmid_no_ack", n_req - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
